// File: rtl/latency_ram_responder_pkg.sv
// Shared constants and state encoding for the wait-state RAM responder.
package latency_ram_responder_pkg;

    localparam int GLOBAL_DATA_WIDTH = 32;
    localparam int MAX_RAM_LATENCY   = 15;
    localparam int LAT_CNT_W         = 4;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_BUSY = 2'd1,
        RAM_RESP = 2'd2
    } ram_state_e;

endpackage

// File: rtl/latency_ram_responder_if.sv
// Request/response bus between the memory controller (master) and the RAM responder (slave).
interface latency_ram_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] addressIn;
    logic [DATA_WIDTH-1:0] dataWriteIn;
    logic [3:0]            byteSelect;
    logic                  store;
    logic                  load;
    logic                  reqReady;
    logic [DATA_WIDTH-1:0] dataReadOut;
    logic                  respValid;
    logic                  addressOutOfRange;

    modport master (
        output addressIn, dataWriteIn, byteSelect, store, load,
        input  reqReady, dataReadOut, respValid, addressOutOfRange
    );

    modport slave (
        input  addressIn, dataWriteIn, byteSelect, store, load,
        output reqReady, dataReadOut, respValid, addressOutOfRange
    );
endinterface

// File: rtl/latency_ram_responder_byte_lane_merge.sv
// Combinational byte-lane merge: selected lanes come from wr_data, the rest keep old_word.
module latency_ram_responder_byte_lane_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_LANES-1:0]  byte_sel,
    output logic [DATA_WIDTH-1:0] new_word
);

    always_comb begin
        new_word = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (byte_sel[i]) begin
                new_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/latency_ram_responder.sv
// RAM responder with programmable wait states; optional access counters via RAM_ACCESS_COUNTERS_EN.
//   state    | meaning
//   RAM_IDLE | reqReady high, waiting for load/store
//   RAM_BUSY | request committed, counting down wait states
//   RAM_RESP | one-cycle respValid with read data / error flag
module latency_ram_responder
    import latency_ram_responder_pkg::*;
#(
    parameter int DATA_WIDTH = GLOBAL_DATA_WIDTH,
    parameter int MEM_BYTES  = 4096,
    parameter int LATENCY    = 3
) (
    input  logic clk,
    input  logic reset,
    latency_ram_responder_if.slave bus
`ifdef RAM_ACCESS_COUNTERS_EN
    ,
    output logic [31:0] loadCount,
    output logic [31:0] storeCount,
    output logic [15:0] errorCount
`endif
);

    localparam int DEPTH = MEM_BYTES / 4;
    localparam int IDX_W = $clog2(MEM_BYTES) - 2;
    localparam logic [DATA_WIDTH-1:0] MEM_LIMIT = DATA_WIDTH'(MEM_BYTES);

    ram_state_e            state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  oor_q, oor_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  oor_in;
    logic                  accept;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] new_word;
    logic                  unused_addr_lsb;

    assign idx             = bus.addressIn[IDX_W+1:2];
    assign unused_addr_lsb = ^bus.addressIn[1:0];
    assign oor_in          = bus.addressIn >= MEM_LIMIT;
    assign accept          = (state_q == RAM_IDLE) && (bus.load || bus.store);
    assign old_word        = mem[idx];
    assign wr_en           = accept && bus.store && !oor_in;

    latency_ram_responder_byte_lane_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (4)
    ) u_merge (
        .old_word (old_word),
        .wr_data  (bus.dataWriteIn),
        .byte_sel (bus.byteSelect),
        .new_word (new_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        oor_d     = oor_q;
        case (state_q)
            RAM_IDLE: begin
                if (accept) begin
                    rd_data_d = oor_in ? '0 : old_word;
                    oor_d     = oor_in;
                    if (LATENCY == 1) begin
                        state_d = RAM_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = RAM_BUSY;
                        cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    end
                end
            end
            RAM_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = RAM_RESP;
                end
            end
            RAM_RESP: state_d = RAM_IDLE;
            default:  state_d = RAM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RAM_IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            oor_q     <= oor_d;
        end
    end

    // Storage is never reset; a store commits on its accept edge regardless of later resets.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= new_word;
        end
    end

    assign bus.reqReady          = (state_q == RAM_IDLE);
    assign bus.respValid         = (state_q == RAM_RESP);
    assign bus.dataReadOut       = bus.respValid ? rd_data_q : '0;
    assign bus.addressOutOfRange = bus.respValid && oor_q;

`ifdef RAM_ACCESS_COUNTERS_EN
    logic [31:0] load_count_q, load_count_d;
    logic [31:0] store_count_q, store_count_d;
    logic [15:0] error_count_q, error_count_d;

    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        error_count_d = error_count_q;
        if (accept) begin
            if (bus.load)  load_count_d  = load_count_q + 32'd1;
            if (bus.store) store_count_d = store_count_q + 32'd1;
            if (oor_in)    error_count_d = error_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_count_q  <= '0;
            store_count_q <= '0;
            error_count_q <= '0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign loadCount  = load_count_q;
    assign storeCount = store_count_q;
    assign errorCount = error_count_q;
`endif

endmodule

// File: tb/tb_latency_ram_responder.sv
// Bench for latency_ram_responder: directed and random requests against a word/lane memory model.
module tb_latency_ram_responder;

    localparam int MEM_BYTES = 4096;
    localparam int LAT_A     = 3;
    localparam int LAT_B     = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    latency_ram_responder_if #(.DATA_WIDTH(32)) bus_a ();
    latency_ram_responder_if #(.DATA_WIDTH(32)) bus_b ();

`ifdef RAM_ACCESS_COUNTERS_EN
    logic [31:0] load_cnt_a, store_cnt_a, load_cnt_b, store_cnt_b;
    logic [15:0] err_cnt_a, err_cnt_b;
`endif

    latency_ram_responder #(.DATA_WIDTH(32), .MEM_BYTES(MEM_BYTES), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
`ifdef RAM_ACCESS_COUNTERS_EN
        ,
        .loadCount  (load_cnt_a),
        .storeCount (store_cnt_a),
        .errorCount (err_cnt_a)
`endif
    );

    latency_ram_responder #(.DATA_WIDTH(32), .MEM_BYTES(MEM_BYTES), .LATENCY(LAT_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
`ifdef RAM_ACCESS_COUNTERS_EN
        ,
        .loadCount  (load_cnt_b),
        .storeCount (store_cnt_b),
        .errorCount (err_cnt_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem   [1024];
    logic [3:0]  model_known [1024];
    int loads_a = 0, stores_a = 0, errs_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on DUT A; request is held through BUSY to show it is not re-accepted.
    task automatic req_a(input bit ld, input bit st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd, mask;
        bit          oor, seen;
        int          idx, cyc;
        oor    = (addr >= MEM_BYTES);
        idx    = int'(addr[11:2]);
        exp_rd = '0;
        mask   = '1;
        if (!oor) begin
            exp_rd = model_mem[idx];
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{model_known[idx][i]}};
        end
        @(negedge clk);
        check({tag, "_ready_before"}, 32'(bus_a.reqReady), 32'd1);
        bus_a.load        = ld;
        bus_a.store       = st;
        bus_a.addressIn   = addr;
        bus_a.dataWriteIn = data;
        bus_a.byteSelect  = be;
        @(posedge clk);
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_a.respValid === 1'b1) seen = 1;
            else check({tag, "_ready_busy"}, 32'(bus_a.reqReady), 32'd0);
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LAT_A));
        check({tag, "_ready_resp"}, 32'(bus_a.reqReady), 32'd0);
        check({tag, "_data"}, bus_a.dataReadOut & mask, exp_rd & mask);
        check({tag, "_oor"}, 32'(bus_a.addressOutOfRange), 32'(oor));
        rd          = bus_a.dataReadOut;
        bus_a.load  = 1'b0;
        bus_a.store = 1'b0;
        if (st && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model_mem[idx][8*i +: 8] = data[8*i +: 8];
            end
            model_known[idx] = model_known[idx] | be;
        end
        loads_a  += int'(ld);
        stores_a += int'(st);
        errs_a   += int'(oor);
        @(negedge clk);
        check({tag, "_valid_after"}, 32'(bus_a.respValid), 32'd0);
        check({tag, "_ready_after"}, 32'(bus_a.reqReady), 32'd1);
        check({tag, "_data_after"}, bus_a.dataReadOut, 32'd0);
        check({tag, "_oor_after"}, 32'(bus_a.addressOutOfRange), 32'd0);
`ifdef RAM_ACCESS_COUNTERS_EN
        check({tag, "_load_cnt"}, load_cnt_a, 32'(loads_a));
        check({tag, "_store_cnt"}, store_cnt_a, 32'(stores_a));
        check({tag, "_err_cnt"}, 32'(err_cnt_a), 32'(errs_a & 16'hFFFF));
`endif
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, addr, data;
        logic [3:0]  be;
        int          kind, sel, nresp;
        bit          exp_v;

        for (int i = 0; i < 1024; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 4'h0;
        end
        reset = 1'b0;
        bus_a.load = 0; bus_a.store = 0; bus_a.addressIn = 0; bus_a.dataWriteIn = 0; bus_a.byteSelect = 0;
        bus_b.load = 0; bus_b.store = 0; bus_b.addressIn = 0; bus_b.dataWriteIn = 0; bus_b.byteSelect = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus_a.reqReady), 32'd1);
        check("rst_valid", 32'(bus_a.respValid), 32'd0);
        check("rst_data", bus_a.dataReadOut, 32'd0);
        check("rst_oor", 32'(bus_a.addressOutOfRange), 32'd0);
        check("rst_ready_b", 32'(bus_b.reqReady), 32'd1);
        reset = 1'b1;

        req_a(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "t1_store", rd);
        req_a(1, 0, 32'h10, 32'h0, 4'h0, "t1_load", rd);
        check("t1_value", rd, 32'hDEADBEEF);

        req_a(0, 1, 32'h20, 32'h11223344, 4'hF, "t2_init", rd);
        req_a(0, 1, 32'h20, 32'h000000AA, 4'b0001, "t2_lane", rd);
        req_a(1, 0, 32'h20, 32'h0, 4'h0, "t2_load", rd);
        check("t2_value", rd, 32'h112233AA);

        req_a(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, "t2_nobe", rd);
        req_a(1, 0, 32'h20, 32'h0, 4'h0, "t2_nobe_load", rd);
        check("t2_nobe_value", rd, 32'h112233AA);

        req_a(0, 1, 32'hFFC, 32'h0F0F0F0F, 4'hF, "t3_edge_st", rd);
        req_a(0, 1, 32'h1000, 32'h12345678, 4'hF, "t3_oor_st", rd);
        req_a(1, 0, 32'h1000, 32'h0, 4'h0, "t3_oor_ld", rd);
        check("t3_oor_value", rd, 32'h0);
        req_a(1, 0, 32'hFFC, 32'h0, 4'h0, "t3_edge_ld", rd);
        check("t3_edge_value", rd, 32'h0F0F0F0F);
        req_a(1, 0, 32'h0, 32'h0, 4'h0, "t3_alias_ld", rd);

        req_a(0, 1, 32'h30, 32'h55555555, 4'hF, "t4_init", rd);
        req_a(1, 1, 32'h30, 32'h00000000, 4'hF, "t4_rmw", rd);
        check("t4_old", rd, 32'h55555555);
        req_a(1, 0, 32'h30, 32'h0, 4'h0, "t4_load", rd);
        check("t4_new", rd, 32'h0);

        @(negedge clk);
        bus_a.store = 1; bus_a.addressIn = 32'h40; bus_a.dataWriteIn = 32'hCAFEF00D; bus_a.byteSelect = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy_ready", 32'(bus_a.reqReady), 32'd0);
        reset = 1'b0;
        #1;
        check("t5_rst_ready", 32'(bus_a.reqReady), 32'd1);
        check("t5_rst_valid", 32'(bus_a.respValid), 32'd0);
        check("t5_rst_data", bus_a.dataReadOut, 32'd0);
        check("t5_rst_oor", 32'(bus_a.addressOutOfRange), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_resp", 32'(bus_a.respValid), 32'd0);
        end
        bus_a.store = 0;
        model_mem[16]   = 32'hCAFEF00D;
        model_known[16] = 4'hF;
        loads_a = 0; stores_a = 0; errs_a = 0;
        @(negedge clk);
        reset = 1'b1;
        req_a(1, 0, 32'h40, 32'h0, 4'h0, "t5_load", rd);
        check("t5_value", rd, 32'hCAFEF00D);

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            else if (sel == 1) addr = 32'hFFFFFFF0;
            else if (sel == 2) addr = 32'hFFC;
            else               addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            kind = $urandom_range(0, 2);
            data = $urandom;
            be   = 4'($urandom_range(0, 15));
            req_a(kind != 1, kind != 0, addr, data, be, "rnd", rd);
        end

        @(negedge clk);
        bus_b.store = 1; bus_b.addressIn = 32'h0; bus_b.dataWriteIn = 32'h0BADCAFE; bus_b.byteSelect = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("t6_store_valid", 32'(bus_b.respValid), 32'd1);
        check("t6_store_ready", 32'(bus_b.reqReady), 32'd0);
        bus_b.store = 0;
        @(negedge clk);
        check("t6_store_done", 32'(bus_b.respValid), 32'd0);
        bus_b.load = 1;
        nresp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_v = (i % 2 == 0);
            check("t6_b2b_valid", 32'(bus_b.respValid), 32'(exp_v));
            check("t6_b2b_data", bus_b.dataReadOut, exp_v ? 32'h0BADCAFE : 32'h0);
            if (bus_b.respValid === 1'b1) nresp++;
        end
        bus_b.load = 0;
        check("t6_nresp", 32'(nresp), 32'd6);
`ifdef RAM_ACCESS_COUNTERS_EN
        @(negedge clk);
        check("t6_load_cnt", load_cnt_b, 32'd6);
        check("t6_store_cnt", store_cnt_b, 32'd1);
        check("t6_err_cnt", 32'(err_cnt_b), 32'd0);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latency_ram_responder.md
Name: latency_ram_responder

Overview:
- Memory-side responder for the memory controller's RAM port: accepts load/store requests carrying a word address, write data and a 4-bit byte-lane select.
- Returns read data or write completion after a programmable number of wait-state cycles, with an explicit ready/valid handshake.
- Replaces the zero-wait-state behavioural RAM in core-level benches so the controller and core are exercised against a slow memory.
- Sits between memoryController (initiator) and nothing downstream: it owns the storage array.

Parameters:
- DATA_WIDTH, 32, data/address width; must equal the global `DATA_WIDTH.
- MEM_BYTES, 4096, memory size in bytes; multiple of 4; depth = MEM_BYTES/4 words.
- LATENCY, 3, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- addressIn  in  DATA_WIDTH  byte address; bits [1:0] ignored
- dataWriteIn  in  DATA_WIDTH  store data, lane-aligned
- byteSelect  in  4  write-enable per byte lane; bit i covers [8i+7:8i]
- store  in  1  store request
- load  in  1  load request
- reqReady  out  1  responder can accept a request this cycle
- dataReadOut  out  DATA_WIDTH  read word; valid only while respValid
- respValid  out  1  one-cycle response pulse (load and store)
- addressOutOfRange  out  1  error flag qualified by respValid

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, reqReady=1, respValid=0, dataReadOut=0, addressOutOfRange=0, wait counter=0. Memory contents are not cleared.
- Accept: on a rising edge with state IDLE and (load|store)=1. Requests are ignored while reqReady=0; the initiator holds them.
- Accept edge N:
  - Latch the word index addressIn[log2(MEM_BYTES)-1:2].
  - Range check: oor = addressIn >= MEM_BYTES.
  - Read the addressed word, before any write, into the response register.
  - If store && !oor, write each lane with byteSelect[i]=1; other lanes keep their old value.
  - byteSelect=0 with store asserted: no write, normal response.
- load && store together: read-before-write. The response returns the old word and the new lanes are written.
- Out of range:
  - No write.
  - dataReadOut=0 during the response.
  - addressOutOfRange=1 during the respValid cycle only.
- States and transitions:
  - IDLE -> BUSY on accept (counter=LATENCY-1).
  - BUSY decrements the counter and goes to RESP when the counter reaches 0.
  - If LATENCY=1, IDLE -> RESP directly.
  - RESP -> IDLE unconditionally after one cycle.
- Timing:
  - respValid=1 exactly during the cycle following edge N+LATENCY-1.
  - reqReady=0 from edge N through the RESP cycle, back to 1 after edge N+LATENCY.
  - Sustained throughput is one request per LATENCY+1 cycles.
- Outside RESP: dataReadOut and addressOutOfRange are held at 0.
- Reset mid-operation: the pending response is dropped. A store already committed at its accept edge stays in memory.
- The memory initial load uses $readmemh of `programFilename when that macro is defined.

Optional Feature:
- Macro: RAM_ACCESS_COUNTERS_EN.
- When defined:
  - Add outputs loadCount[31:0], storeCount[31:0] and errorCount[15:0].
  - loadCount and storeCount increment at each accept edge per request type (a load+store request increments both).
  - errorCount increments on each out-of-range accept.
  - All counters are cleared by reset and wrap modulo 2^width.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header (globalVariables.v):
  - `DATA_WIDTH
  - state encodings RAM_IDLE=2'd0, RAM_BUSY=2'd1, RAM_RESP=2'd2
  - `MAX_RAM_LATENCY=15
- Sub-module byte_lane_merge: combinational merge of old word, write data and byteSelect into the new word. Reused by any future cache fill path.

Test Plan:
- LATENCY=3, store addr 0x10 data 0xDEADBEEF byteSelect 4'hF at edge 5 -> respValid high in cycle after edge 7 only, reqReady low edges 5..8; then load 0x10 -> dataReadOut=0xDEADBEEF.
- Word 0x20=0x11223344; store 0x000000AA with byteSelect 4'b0001, then load 0x20 -> 0x112233AA.
- Load 0x1000 with MEM_BYTES=4096 -> respValid=1, addressOutOfRange=1, dataReadOut=0; then load 0x0FFC -> addressOutOfRange=0.
- load+store together at 0x30 (old 0x55555555, new 0x0 all lanes) -> response 0x55555555, subsequent load returns 0x0.
- Request held during BUSY and reset pulled low mid-BUSY -> respValid never asserts, reqReady=1 immediately, all outputs 0; the committed store is visible on a later load.
- LATENCY=1, back-to-back loads held asserted -> respValid every second cycle; with RAM_ACCESS_COUNTERS_EN, loadCount=N after N responses.
